custom_buttons_pio: RTL and testbench
=====================================

# custom_buttons_pio

Avalon-MM slave that reads the board's push-buttons and DIP switches into the HPS lightweight bridge address space. It is the input-side counterpart of the custom LED peripheral. Each input is synchronized and debounced. Debounced press edges are latched into a capture register, and an interrupt is raised for unmasked captures.

## Interface
Parameters:
- WIDTH, 4: number of physical inputs (1..32).
- DEBOUNCE_CYCLES, 1000000: number of clk cycles an input must be stable before it is accepted (20 ms at 50 MHz). Minimum 2.
- ACTIVE_LOW, 1: when 1, inputs are inverted so that "pressed" reads as 1.

Ports:
- clk  in  1: single clock for all logic.
- reset_n  in  1: asynchronous, active-low reset.
- avs_s0_address  in  2: word address of the register.
- avs_s0_read  in  1: read strobe.
- avs_s0_readdata  out  32: read data, registered.
- avs_s0_write  in  1: write strobe.
- avs_s0_writedata  in  32: write data.
- irq  out  1: level interrupt to the HPS.
- coe_buttons_in  in  WIDTH: raw asynchronous pin inputs.

## Operation
- Input path for each bit:
  - 2-flop synchronizer.
  - XOR with ACTIVE_LOW to normalize polarity, giving `sync`.
  - Debounce counter producing `stable`.
- Debounce counter, per bit, $clog2(DEBOUNCE_CYCLES) bits wide:
  - When sync == stable, the counter is cleared.
  - When sync != stable and the counter is below DEBOUNCE_CYCLES-1, it increments.
  - When sync != stable and the counter is at DEBOUNCE_CYCLES-1, `stable` takes `sync` and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never reaches `stable`.
- Edge capture: a 0->1 transition of `stable` (a press) sets the matching EDGE bit. Releases are not captured.
- Register map (word offsets):
  - 0 DATA (RO): `stable`, zero-extended to 32 bits.
  - 1 MASK (RW): bits [WIDTH-1:0] are interrupt enables. Upper bits read 0 and writes to them are ignored.
  - 2 EDGE (W1C): captured presses. Writing 1 to a bit clears it; writing 0 leaves it unchanged.
  - 3 RAW (RO): `sync` before debounce, for diagnostics.
- Writes to DATA or RAW are ignored.
- irq = |(EDGE & MASK). It is derived combinationally from flops only and is held until software clears the EDGE bit or the MASK bit.
- Simultaneous W1C clear and new press edge on the same bit in the same cycle: set wins, and the bit stays 1.
- A read and a write in the same cycle is not a legal Avalon transaction. Behaviour in that case is defined only as: the write takes effect, and readdata reflects the pre-write value.

## Timing
- Reset values:
  - sync flops, `stable`, counters, MASK and EDGE are all 0.
  - avs_s0_readdata is 0.
  - irq is 0.
- Read latency is fixed at 1. avs_s0_readdata is valid on the cycle after avs_s0_read is sampled and holds until the next read. No waitrequest.
- Writes complete in the cycle they are sampled. A register written at edge t reads back its new value if the read is sampled at t+1.
- Pin-to-`sync` delay: 2 cycles.
- `sync`-to-`stable` delay: if `sync` changes after edge t and stays constant, `stable` updates at edge t+DEBOUNCE_CYCLES. The EDGE bit sets at the same edge, and irq rises in the same cycle if the bit is unmasked.
- Inputs held pressed through reset are accepted as a press DEBOUNCE_CYCLES+2 cycles after reset_n deasserts, and they set EDGE.
- Assertion of reset_n mid-debounce discards all progress. There are no partial carries across reset.
- The counter never wraps; it saturates at the acceptance point and then clears.

## Structure
- Shared package soc_pio_pkg holds:
  - register offsets REG_DATA=0, REG_MASK=1, REG_EDGE=2, REG_RAW=3;
  - the data bus width constant 32.
- Sub-module pio_debounce is instantiated WIDTH times and contains the synchronizer, polarity inversion and counter for one bit. Parameters: DEBOUNCE_CYCLES, ACTIVE_LOW. Outputs: `sync`, `stable`.
- The top level contains the register file, edge detect, irq and read mux.

## Test plan
All scenarios use DEBOUNCE_CYCLES=8, WIDTH=4, ACTIVE_LOW=1.
1. Hold coe_buttons_in=4'b1111 out of reset -> DATA=0, EDGE=0 and irq=0 indefinitely. Drive bit0 low -> DATA=1 exactly 2+8 cycles later, and EDGE=1.
2. Pulse bit1 low for 5 cycles -> RAW shows the pulse, while DATA and EDGE stay 0. Then bounce bit1 (3 low, 2 high, 10 low) -> exactly one EDGE bit1 set, 8 cycles after the final low is synchronized.
3. Write MASK=0x4, then press bit2 -> irq=1. Write EDGE=0x4 -> irq=0 on the next cycle, and EDGE reads 0. Pressing bit3 while MASK=0x4 sets EDGE bit3 but irq stays 0.
4. Issue the EDGE W1C for bit0 on the same cycle that bit0's press is accepted -> EDGE bit0 reads 1 afterwards.
5. Read each offset -> readdata valid one cycle after the read. Write 0xFFFFFFFF to MASK -> MASK reads 0x0000000F. Writes to DATA and RAW do not change their read values.
6. Assert reset_n low when a counter is at 6 of 8 -> all outputs return to reset values. After release, a held press is accepted 10 cycles later.

Source files
------------

// File: rtl/soc_pio_pkg.sv
// Shared definitions for the HPS lightweight-bridge PIO peripherals:
// bus width and the word offsets of the button register map.
package soc_pio_pkg;

  localparam int DATA_W = 32;

  typedef logic [1:0] reg_addr_t;

  localparam reg_addr_t REG_DATA = 2'd0;
  localparam reg_addr_t REG_MASK = 2'd1;
  localparam reg_addr_t REG_EDGE = 2'd2;
  localparam reg_addr_t REG_RAW  = 2'd3;

endpackage

// File: rtl/pio_debounce.sv
// One input bit: 2-flop synchronizer (polarity normalized at its input so the
// flops reset to "not pressed"), then a saturating stability counter.
module pio_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic sync,
  output logic stable,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q, meta_d;
  logic             sync_q, sync_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    meta_d   = pin ^ ACTIVE_LOW;
    sync_d   = meta_q;
    stable_d = stable_q;
    cnt_d    = '0;
    press    = 1'b0;
    if (sync_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = sync_q;
        // press is asserted on the same edge stable rises, so EDGE sets with it
        press    = sync_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      meta_q   <= meta_d;
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign sync   = sync_q;
  assign stable = stable_q;

endmodule

// File: rtl/custom_buttons_pio.sv
// Avalon-MM button/switch input peripheral: debounced DATA, interrupt MASK,
// W1C press-capture EDGE and raw synchronized RAW, with a level irq.
module custom_buttons_pio
  import soc_pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        avs_s0_address,
  input  logic              avs_s0_read,
  output logic [DATA_W-1:0] avs_s0_readdata,
  input  logic              avs_s0_write,
  input  logic [DATA_W-1:0] avs_s0_writedata,
  output logic              irq,
  input  logic [WIDTH-1:0]  coe_buttons_in
);

  // Handshake: read strobe sampled at edge t gives readdata after t, held
  // until the next read; writes take effect at the sampling edge; no waitrequest.

  logic [WIDTH-1:0]  sync_w, stable_w, press_w;
  logic [WIDTH-1:0]  mask_q, mask_d;
  logic [WIDTH-1:0]  edge_q, edge_d;
  logic [WIDTH-1:0]  edge_clr;
  logic [DATA_W-1:0] readdata_q, readdata_d;
  logic [DATA_W-1:0] wdata_unused;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pio_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_debounce (
      .clk     (clk),
      .reset_n (reset_n),
      .pin     (coe_buttons_in[i]),
      .sync    (sync_w[i]),
      .stable  (stable_w[i]),
      .press   (press_w[i])
    );
  end

  // Only the low WIDTH write bits land anywhere.
  assign wdata_unused = avs_s0_writedata;

  always_comb begin
    mask_d   = mask_q;
    edge_clr = '0;
    if (avs_s0_write && avs_s0_address == REG_MASK) mask_d = avs_s0_writedata[WIDTH-1:0];
    if (avs_s0_write && avs_s0_address == REG_EDGE) edge_clr = avs_s0_writedata[WIDTH-1:0];
    // A press accepted in the same cycle as its W1C clear wins
    edge_d = (edge_q & ~edge_clr) | press_w;

    readdata_d = readdata_q;
    if (avs_s0_read) begin
      case (avs_s0_address)
        REG_DATA: readdata_d = DATA_W'(stable_w);
        REG_MASK: readdata_d = DATA_W'(mask_q);
        REG_EDGE: readdata_d = DATA_W'(edge_q);
        REG_RAW:  readdata_d = DATA_W'(sync_w);
        default:  readdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q     <= '0;
      edge_q     <= '0;
      readdata_q <= '0;
    end else begin
      mask_q     <= mask_d;
      edge_q     <= edge_d;
      readdata_q <= readdata_d;
    end
  end

  assign avs_s0_readdata = readdata_q;
  assign irq             = |(edge_q & mask_q);

endmodule

// File: tb/tb_custom_buttons_pio.sv
// Directed bench for custom_buttons_pio (WIDTH=4, DEBOUNCE_CYCLES=8, ACTIVE_LOW=1).
module tb_custom_buttons_pio;
  import soc_pio_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        irq;
  logic [3:0]  buttons = 4'hF;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  logic [1:0]  addr_q[$];
  logic        rd_pend = 1'b0;

  custom_buttons_pio #(
    .WIDTH           (4),
    .DEBOUNCE_CYCLES (8),
    .ACTIVE_LOW      (1'b1)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .avs_s0_address   (address),
    .avs_s0_read      (read),
    .avs_s0_readdata  (readdata),
    .avs_s0_write     (write),
    .avs_s0_writedata (writedata),
    .irq              (irq),
    .coe_buttons_in   (buttons)
  );

  // clock/reset block
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e);
    address = a;
    read    = 1'b1;
    exp_q.push_back(e);
    addr_q.push_back(a);
    step();
    read = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write     = 1'b1;
    step();
    write = 1'b0;
  endtask

  // scoreboard monitor: readdata is due on the edge after a sampled read
  always @(posedge clk) rd_pend <= read;

  always @(negedge clk) begin
    if (rd_pend) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_read: got 0x%08h with empty expected queue", readdata);
      end else begin
        logic [31:0] e;
        logic [1:0]  a;
        e = exp_q.pop_front();
        a = addr_q.pop_front();
        check($sformatf("read_off%0d", a), readdata, e);
      end
    end
  end

  initial begin
    // reset with all buttons released (pins high)
    step(3);
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    reset_n = 1'b1;

    // 1: idle released inputs, then press bit0
    step(20);
    rd(REG_DATA, 32'h0);
    rd(REG_EDGE, 32'h0);
    rd(REG_RAW, 32'h0);
    check("idle_irq", {31'b0, irq}, 32'h0);
    buttons = 4'b1110;
    for (int j = 1; j <= 11; j++) rd(REG_DATA, (j == 11) ? 32'h1 : 32'h0);
    rd(REG_EDGE, 32'h1);
    check("t1_irq_masked", {31'b0, irq}, 32'h0);
    wr(REG_EDGE, 32'h1);
    rd(REG_EDGE, 32'h0);

    // 2: 5-cycle glitch on bit1 is visible in RAW only
    buttons = 4'b1100;
    for (int k = 1; k <= 5; k++) rd(REG_RAW, (k >= 3) ? 32'h3 : 32'h1);
    buttons = 4'b1110;
    step(12);
    rd(REG_DATA, 32'h1);
    rd(REG_EDGE, 32'h0);
    rd(REG_RAW, 32'h1);
    // bounce: 3 low, 2 high, then low and held
    buttons = 4'b1100;
    step(3);
    buttons = 4'b1110;
    step(2);
    buttons = 4'b1100;
    for (int j = 1; j <= 11; j++) rd(REG_DATA, (j == 11) ? 32'h3 : 32'h1);
    rd(REG_EDGE, 32'h2);
    wr(REG_EDGE, 32'h2);
    rd(REG_EDGE, 32'h0);

    // 3: masked interrupt
    wr(REG_MASK, 32'h4);
    rd(REG_MASK, 32'h4);
    buttons = 4'b1000;
    step(12);
    check("t3_irq_set", {31'b0, irq}, 32'h1);
    rd(REG_EDGE, 32'h4);
    wr(REG_EDGE, 32'h4);
    check("t3_irq_clear", {31'b0, irq}, 32'h0);
    rd(REG_EDGE, 32'h0);
    buttons = 4'b0000;
    step(12);
    check("t3_irq_unmasked_bit", {31'b0, irq}, 32'h0);
    rd(REG_EDGE, 32'h8);
    wr(REG_EDGE, 32'h8);

    // 4: W1C on the same edge bit0's press is accepted
    buttons = 4'b0001;
    step(12);
    wr(REG_EDGE, 32'hF);
    rd(REG_EDGE, 32'h0);
    buttons = 4'b0000;
    step(9);
    wr(REG_EDGE, 32'h1);
    rd(REG_EDGE, 32'h1);

    // 5: register map
    rd(REG_DATA, 32'hF);
    rd(REG_MASK, 32'h4);
    rd(REG_EDGE, 32'h1);
    rd(REG_RAW, 32'hF);
    wr(REG_MASK, 32'hFFFF_FFFF);
    rd(REG_MASK, 32'hF);
    check("t5_irq_full_mask", {31'b0, irq}, 32'h1);
    wr(REG_DATA, 32'h0);
    rd(REG_DATA, 32'hF);
    wr(REG_RAW, 32'h0);
    rd(REG_RAW, 32'hF);

    // 6: reset with bit2's counter at 6 of 8
    buttons = 4'hF;
    step(12);
    rd(REG_MASK, 32'hF);
    buttons = 4'b1011;
    step(8);
    reset_n = 1'b0;
    #1;
    check("t6_reset_readdata", readdata, 32'h0);
    check("t6_reset_irq", {31'b0, irq}, 32'h0);
    step(3);
    reset_n = 1'b1;
    for (int j = 1; j <= 11; j++) rd(REG_DATA, (j == 11) ? 32'h4 : 32'h0);
    rd(REG_EDGE, 32'h4);
    rd(REG_MASK, 32'h0);
    check("t6_irq_mask_reset", {31'b0, irq}, 32'h0);
    wr(REG_MASK, 32'h4);
    check("t6_irq_after_mask", {31'b0, irq}, 32'h1);

    step(2);
    check("queue_drained", exp_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
